// File: rtl/ofs_fim_if_pkg.sv
// PCIe TX AXI-S beat types shared by the FIM TX path.
// Beats carry FIM_PCIE_TLP_CH TLP channels plus sideband tuser.
package ofs_fim_if_pkg;

    localparam int FIM_PCIE_TLP_CH = 2;
    localparam int CH0             = 0;
    localparam int CH1             = 1;
    localparam int PCIE_CH_DATA_W  = 32;
    localparam int PCIE_TUSER_W    = 8;

    typedef struct packed {
        logic                      valid;
        logic                      sop;
        logic                      eop;
        logic [PCIE_CH_DATA_W-1:0] data;
    } t_axis_pcie_tdata;

    typedef struct packed {
        t_axis_pcie_tdata [FIM_PCIE_TLP_CH-1:0] tdata;
        logic [PCIE_TUSER_W-1:0]                tuser;
    } t_axis_pcie_txs;

    // A beat closes when its highest valid channel carries eop.
    function automatic logic pcie_txs_closes(input t_axis_pcie_txs tx);
        logic c;
        c = 1'b0;
        for (int ch = 0; ch < FIM_PCIE_TLP_CH; ch++) begin
            if (tx.tdata[ch].valid) begin
                c = tx.tdata[ch].eop;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_pkt_arbiter_pkg.sv
// Local types and helpers for the TX packet arbiter.
package tx_pkt_arbiter_pkg;

    import ofs_fim_if_pkg::*;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    function automatic logic pcie_txs_has_data(input t_axis_pcie_txs tx);
        logic v;
        v = 1'b0;
        for (int ch = 0; ch < FIM_PCIE_TLP_CH; ch++) begin
            v = v | tx.tdata[ch].valid;
        end
        return v;
    endfunction

endpackage

// File: rtl/tx_pkt_arbiter_rr_arb_onehot.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_arb_onehot #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-level round-robin arbiter onto one PCIe TX AXI-S stream.
// Ownership is held from a packet's first beat until its closing beat.
module tx_pkt_arbiter
    import ofs_fim_if_pkg::*;
    import tx_pkt_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int STALL_LIMIT = 1024,
    parameter int STALL_CNT_W = $clog2(STALL_LIMIT + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQ-1:0]                           i_tvalid,
    input  logic [NUM_REQ-1:0][$bits(t_axis_pcie_txs)-1:0] i_tx,
    output logic [NUM_REQ-1:0]                           o_tready,
    output logic                                         o_tvalid,
    output logic [$bits(t_axis_pcie_txs)-1:0]            o_tx,
    input  logic                                         i_tready,
    output logic [NUM_REQ-1:0]                           o_grant,
    output logic [NUM_REQ-1:0]                           o_stall_err,
    input  logic                                         i_stall_clr
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX = STALL_CNT_W'(STALL_LIMIT);
    localparam logic [STALL_CNT_W-1:0] CNT_SET = STALL_CNT_W'(STALL_LIMIT - 1);

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 tvalid_q, tvalid_d;
    t_axis_pcie_txs       tx_q, tx_d;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   ready;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     sel_idx;
    t_axis_pcie_txs       sel_tx;
    logic                 stage_ready;
    logic                 accept;
    logic                 sel_closes;
    logic                 stall_inc;
    logic                 err_set;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req[r] = i_tvalid[r] && pcie_txs_has_data(i_tx[r]);
        end
    end

    rr_arb_onehot #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req (req),
        .ptr (rr_q),
        .gnt (gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    assign stage_ready = ~tvalid_q | i_tready;

    // Output process: who sees ready, and what gets accepted.
    always_comb begin
        ready = '0;
        if (!rst && stage_ready) begin
            if (state_q == ARB_IDLE) begin
                ready = gnt;
            end else begin
                ready[owner_q] = 1'b1;
            end
        end
        sel_idx    = (state_q == ARB_IDLE) ? win_idx : owner_q;
        sel_tx     = i_tx[sel_idx];
        accept     = |(ready & i_tvalid);
        sel_closes = pcie_txs_closes(sel_tx);
        o_grant    = '0;
        if (state_q == ARB_LOCK) begin
            o_grant[owner_q] = 1'b1;
        end
    end

    assign o_tready    = ready;
    assign o_tvalid    = tvalid_q;
    assign o_tx        = tx_q;
    assign o_stall_err = err_q;

    // Next-state process.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    if (sel_closes) begin
                        rr_d = next_ptr(sel_idx);
                    end else begin
                        state_d = ARB_LOCK;
                        owner_d = sel_idx;
                    end
                end
            end
            ARB_LOCK: begin
                if (accept && sel_closes) begin
                    state_d = ARB_IDLE;
                    rr_d    = next_ptr(owner_q);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Stall watchdog only counts owner idleness the stage could have taken.
    always_comb begin
        stall_inc = (state_q == ARB_LOCK) && !i_tvalid[owner_q] && stage_ready;
        err_set   = stall_inc && (cnt_q == CNT_SET);
        if ((state_q == ARB_IDLE) || accept) begin
            cnt_d = '0;
        end else if (stall_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        err_d = i_stall_clr ? '0 : err_q;
        if (err_set) begin
            err_d[owner_q] = 1'b1;
        end
        tvalid_d = accept | (tvalid_q & ~i_tready);
        tx_d     = accept ? sel_tx : tx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            tvalid_q <= 1'b0;
            tx_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tvalid_q <= tvalid_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Random and directed bench for tx_pkt_arbiter against a cycle model.
// The model keeps owner/pointer as plain integers and a staged output beat.
module tb_tx_pkt_arbiter;

    import ofs_fim_if_pkg::*;

    localparam int N     = 4;
    localparam int LIMIT = 1024;
    localparam int TXS_W = $bits(t_axis_pcie_txs);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N-1:0]              i_tvalid;
    logic [N-1:0][TXS_W-1:0]   i_tx;
    logic [N-1:0]              o_tready;
    logic                      o_tvalid;
    logic [TXS_W-1:0]          o_tx;
    logic                      i_tready;
    logic [N-1:0]              o_grant;
    logic [N-1:0]              o_stall_err;
    logic                      i_stall_clr;

    tx_pkt_arbiter #(
        .NUM_REQ     (N),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tvalid    (i_tvalid),
        .i_tx        (i_tx),
        .o_tready    (o_tready),
        .o_tvalid    (o_tvalid),
        .o_tx        (o_tx),
        .i_tready    (i_tready),
        .o_grant     (o_grant),
        .o_stall_err (o_stall_err),
        .i_stall_clr (i_stall_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tag_ctr  = 100;

    int             m_owner;
    int             m_ptr;
    int             m_cnt;
    int             m_acc;
    logic [N-1:0]   m_err;
    logic           m_ov;
    t_axis_pcie_txs m_otx;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_closes(input t_axis_pcie_txs b);
        for (int ch = FIM_PCIE_TLP_CH - 1; ch >= 0; ch--) begin
            if (b.tdata[ch].valid) return b.tdata[ch].eop;
        end
        return 1'b0;
    endfunction

    function automatic bit tb_has(input t_axis_pcie_txs b);
        for (int ch = 0; ch < FIM_PCIE_TLP_CH; ch++) begin
            if (b.tdata[ch].valid) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int k;
        r = '0;
        if (rst || !(!m_ov || i_tready)) return r;
        if (m_owner >= 0) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (i_tvalid[k] && tb_has(i_tx[k])) begin
                r[k] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_acc   = -1;
        m_err   = '0;
        m_ov    = 1'b0;
        m_otx   = '0;
    endtask

    task automatic model_update(input logic [N-1:0] er);
        t_axis_pcie_txs b;
        bit sr;
        int acc;
        acc = -1;
        sr  = !m_ov || i_tready;
        for (int k = 0; k < N; k++) begin
            if (er[k] && i_tvalid[k]) acc = k;
        end
        if (rst) begin
            model_reset();
            return;
        end
        m_acc = acc;
        if (i_stall_clr) m_err = '0;
        if (m_owner >= 0 && acc < 0 && !i_tvalid[m_owner] && sr) begin
            if (m_cnt == LIMIT - 1) m_err[m_owner] = 1'b1;
            if (m_cnt < LIMIT) m_cnt++;
        end
        if (acc >= 0) begin
            b     = i_tx[acc];
            m_ov  = 1'b1;
            m_otx = b;
            m_cnt = 0;
            if (tb_closes(b)) begin
                m_owner = -1;
                m_ptr   = (acc + 1) % N;
            end else begin
                m_owner = acc;
            end
        end else if (i_tready) begin
            m_ov = 1'b0;
        end
    endtask

    // One clock: compare at negedge, advance the model, return after posedge.
    task automatic step();
        logic [N-1:0] er;
        @(negedge clk);
        er = model_ready();
        check("tready", 128'(o_tready), 128'(er));
        check("tvalid", 128'(o_tvalid), 128'(m_ov));
        if (m_ov) check("tx", 128'(o_tx), 128'(m_otx));
        check("grant", 128'(o_grant), 128'(model_grant()));
        check("stall_err", 128'(o_stall_err), 128'(m_err));
        model_update(er);
        @(posedge clk);
        #1;
    endtask

    function automatic t_axis_pcie_txs mk(input int tag, input bit v0,
                                          input bit v1, input bit e0,
                                          input bit e1);
        t_axis_pcie_txs b;
        b = '0;
        b.tdata[CH0].valid = v0;
        b.tdata[CH0].sop   = 1'b1;
        b.tdata[CH0].eop   = e0;
        b.tdata[CH0].data  = 32'(tag);
        b.tdata[CH1].valid = v1;
        b.tdata[CH1].eop   = e1;
        b.tdata[CH1].data  = ~32'(tag);
        b.tuser            = 8'(tag);
        return b;
    endfunction

    function automatic t_axis_pcie_txs gen_beat(input bit last, input int tag);
        t_axis_pcie_txs b;
        int mode;
        b    = '0;
        mode = int'($urandom_range(0, 2));
        b.tuser = 8'($urandom);
        for (int ch = 0; ch < FIM_PCIE_TLP_CH; ch++) begin
            b.tdata[ch].data = $urandom;
            b.tdata[ch].sop  = 1'($urandom);
        end
        b.tdata[CH0].data = 32'(tag);
        case (mode)
            0: begin
                b.tdata[CH0].valid = 1'b1;
                b.tdata[CH0].eop   = last;
            end
            1: begin
                b.tdata[CH1].valid = 1'b1;
                b.tdata[CH1].eop   = last;
            end
            default: begin
                b.tdata[CH0].valid = 1'b1;
                b.tdata[CH0].eop   = 1'($urandom);
                b.tdata[CH1].valid = 1'b1;
                b.tdata[CH1].eop   = last;
            end
        endcase
        return b;
    endfunction

    task automatic idle_inputs();
        i_tvalid    = '0;
        i_tx        = '0;
        i_tready    = 1'b1;
        i_stall_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        t_axis_pcie_txs cur [N];
        int left [N];
        for (int r = 0; r < N; r++) begin
            left[r] = 1 + int'($urandom_range(0, 3));
            tag_ctr++;
            cur[r] = gen_beat(left[r] == 1, tag_ctr);
        end
        m_acc = -1;
        for (int c = 0; c < cycles; c++) begin
            if (m_acc >= 0) begin
                left[m_acc]--;
                if (left[m_acc] == 0) left[m_acc] = 1 + int'($urandom_range(0, 3));
                tag_ctr++;
                cur[m_acc] = gen_beat(left[m_acc] == 1, tag_ctr);
            end
            for (int r = 0; r < N; r++) begin
                i_tvalid[r] = ($urandom_range(0, 99) < 60);
                i_tx[r] = i_tvalid[r] ? TXS_W'(cur[r])
                                      : TXS_W'({$urandom, $urandom, $urandom});
            end
            i_tready    = ($urandom_range(0, 99) < 75);
            i_stall_clr = ($urandom_range(0, 199) == 0);
            step();
        end
    endtask

    t_axis_pcie_txs ba, bb, bc, bd;

    initial begin
        rst = 1'b1;
        idle_inputs();
        i_tvalid[0] = 1'b1;
        i_tx[0]     = mk(1, 1, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_tvalid", 128'(o_tvalid), 128'(0));
        check("rst_chvalid", 128'({o_tx[TXS_W-1], o_tx[TXS_W-1-35]}), 128'(0));
        check("rst_tready", 128'(o_tready), 128'(0));
        check("rst_grant", 128'(o_grant), 128'(0));
        check("rst_err", 128'(o_stall_err), 128'(0));
        idle_inputs();
        rst = 1'b0;

        // Single requester, three-beat TLP.
        ba = mk(1, 1, 1, 0, 0);
        bb = mk(2, 1, 1, 0, 0);
        bc = mk(3, 1, 0, 1, 0);
        i_tvalid = 4'b0001;
        i_tx[0] = ba;
        step();
        check("t1_b1", 128'(o_tx), 128'(ba));
        check("t1_g1", 128'(o_grant), 128'(4'b0001));
        i_tx[0] = bb;
        step();
        check("t1_b2", 128'(o_tx), 128'(bb));
        check("t1_g2", 128'(o_grant), 128'(4'b0001));
        i_tx[0] = bc;
        step();
        check("t1_b3", 128'(o_tx), 128'(bc));
        check("t1_idle", 128'(o_grant), 128'(0));
        i_tvalid = '0;
        step();
        check("t1_drain", 128'(o_tvalid), 128'(0));

        // Simultaneous 1-beat TLPs on req0 and req2 from rr_ptr 0.
        pulse_reset();
        ba = mk(10, 1, 0, 1, 0);
        bb = mk(12, 1, 1, 0, 1);
        i_tvalid = 4'b0101;
        i_tx[0] = ba;
        i_tx[2] = bb;
        step();
        check("t2_req0", 128'(o_tx), 128'(ba));
        i_tvalid = 4'b0100;
        step();
        check("t2_req2", 128'(o_tx), 128'(bb));
        check("t2_nobubble", 128'(o_tvalid), 128'(1));
        bc = mk(20, 1, 0, 1, 0);
        bd = mk(23, 1, 0, 1, 0);
        i_tvalid = 4'b1001;
        i_tx[0] = bc;
        i_tx[3] = bd;
        step();
        check("t2_ptr3", 128'(o_tx), 128'(bd));
        i_tvalid = 4'b0001;
        step();
        i_tvalid = '0;
        step();

        // Req1 locked mid-packet while req3 waits.
        ba = mk(31, 1, 1, 0, 0);
        bb = mk(32, 1, 1, 0, 1);
        bd = mk(33, 1, 0, 1, 0);
        i_tvalid = 4'b0010;
        i_tx[1] = ba;
        step();
        i_tvalid = 4'b1000;
        i_tx[3] = bd;
        repeat (3) begin
            step();
            check("t3_hold", 128'(o_tready[3]), 128'(0));
            check("t3_grant", 128'(o_grant), 128'(4'b0010));
        end
        i_tvalid = 4'b1010;
        i_tx[1] = bb;
        step();
        check("t3_close", 128'(o_tx), 128'(bb));
        i_tvalid = 4'b1000;
        step();
        check("t3_next", 128'(o_tx), 128'(bd));
        i_tvalid = '0;
        step();

        // Downstream backpressure for five cycles.
        ba = mk(40, 1, 1, 0, 0);
        bb = mk(41, 1, 1, 0, 0);
        bc = mk(42, 1, 0, 1, 0);
        i_tvalid = 4'b0001;
        i_tx[0] = ba;
        step();
        i_tready = 1'b0;
        i_tx[0] = bb;
        repeat (5) begin
            step();
            check("t4_stable", 128'(o_tx), 128'(ba));
            check("t4_noready", 128'(o_tready), 128'(0));
        end
        i_tready = 1'b1;
        step();
        check("t4_resume", 128'(o_tx), 128'(bb));
        i_tx[0] = bc;
        step();
        check("t4_last", 128'(o_tx), 128'(bc));
        i_tvalid = '0;
        step();

        // Locked requester goes silent long enough to trip the watchdog.
        ba = mk(50, 1, 1, 0, 0);
        i_tvalid = 4'b0100;
        i_tx[2] = ba;
        step();
        i_tvalid = '0;
        repeat (LIMIT - 1) step();
        check("t5_before", 128'(o_stall_err), 128'(0));
        step();
        check("t5_err", 128'(o_stall_err), 128'(4'b0100));
        check("t5_grant", 128'(o_grant), 128'(4'b0100));
        i_stall_clr = 1'b1;
        step();
        i_stall_clr = 1'b0;
        check("t5_clr", 128'(o_stall_err), 128'(0));
        step();
        check("t5_stay", 128'(o_stall_err), 128'(0));
        i_tvalid = 4'b0100;
        i_tx[2] = mk(51, 1, 0, 1, 0);
        step();
        i_tvalid = '0;
        step();

        // Reset mid-packet, then a fresh requester.
        i_tvalid = 4'b0010;
        i_tx[1] = mk(60, 1, 1, 0, 0);
        step();
        rst = 1'b1;
        i_tvalid = '0;
        step();
        rst = 1'b0;
        check("t6_tvalid", 128'(o_tvalid), 128'(0));
        check("t6_grant", 128'(o_grant), 128'(0));
        bd = mk(63, 1, 1, 0, 0);
        i_tvalid = 4'b1000;
        i_tx[3] = bd;
        step();
        check("t6_fresh", 128'(o_tx), 128'(bd));
        check("t6_lock", 128'(o_grant), 128'(4'b1000));
        i_tx[3] = mk(64, 1, 0, 1, 0);
        step();
        i_tvalid = '0;
        step();

        pulse_reset();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
